// File: rtl/mips_mc_controller_gen2.sv
// Multicycle MIPS control FSM: mem_ready handshake, memory watchdog, illegal-opcode trap, jr and halt.
// Optional `MC_PERF_CNT_EN adds cycle and retired-instruction counters.
module mips_mc_controller_gen2 #(
    parameter int ALUOP_W     = 6,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    output logic               PCWriteCond,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               JumpAndLink,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               halted,
    output logic               err,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_retired
);
    typedef enum logic [3:0] {
        RST_ST, FETCH, DECODE, R_EXEC, R_WB, JR, I_EXEC, I_WB,
        MEM_ADDR, LD_ACC, LD_WB, ST_ACC, BRANCH, JUMP, HALT, ERROR
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(6'b001001);
    localparam bit                 TMO_EN     = (MEM_TIMEOUT > 0);
    localparam int                 TMO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TMO_LAST_I);

    state_t           state, state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [5:0]       opcode, funct;
    logic             tmo_hit, mem_wait, instr_unused;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign instr_unused = ^instr[25:6];
    // The cycle in which the count would reach MEM_TIMEOUT is the last one allowed; ready still wins there.
    assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
    assign mem_wait = (state == FETCH || state == LD_ACC || state == ST_ACC) && !mem_ready
                      && (state_next == state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RST_ST;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= mem_wait ? tmo_cnt + TMO_W'(1) : '0;
        end
    end

    always_comb begin
        state_next  = state;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        JumpAndLink = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = '0;
        halted      = 1'b0;
        err         = 1'b0;
        // Reset forces the all-zero RST_ST output set regardless of the registered state.
        case (rst ? RST_ST : state)
            RST_ST: state_next = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end else if (tmo_hit) begin
                    state_next = ERROR;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                case (opcode)
                    6'b000000:                     state_next = R_EXEC;
                    6'b000010, 6'b000011:          state_next = JUMP;
                    6'b000100, 6'b000101:          state_next = BRANCH;
                    6'b001001, 6'b001010, 6'b001100,
                    6'b001101, 6'b001110, 6'b010000: state_next = I_EXEC;
                    6'b100011, 6'b101011:          state_next = MEM_ADDR;
                    6'b111111:                     state_next = HALT;
                    default:                       state_next = ERROR;
                endcase
            end
            R_EXEC, R_WB: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(opcode);
                if (state == R_WB) begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = (funct == 6'b001000) ? JR : R_WB;
                end
            end
            JR: begin
                PCSource   = 2'b11;
                PCWrite    = 1'b1;
                state_next = FETCH;
            end
            I_EXEC, I_WB: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_W'(opcode);
                if (state == I_WB) begin
                    RegWrite   = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = I_WB;
                end
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = ALU_ADD;
                state_next = (opcode == 6'b101011) ? ST_ACC : LD_ACC;
            end
            LD_ACC: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)    state_next = LD_WB;
                else if (tmo_hit) state_next = ERROR;
            end
            LD_WB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            ST_ACC: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)    state_next = FETCH;
                else if (tmo_hit) state_next = ERROR;
            end
            BRANCH: begin
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(opcode);
                state_next  = FETCH;
            end
            JUMP: begin
                PCWrite     = 1'b1;
                PCSource    = 2'b10;
                JumpAndLink = (opcode == 6'b000011);
                state_next  = FETCH;
            end
            HALT:    halted = 1'b1;
            ERROR:   err    = 1'b1;
            default: state_next = ERROR;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state_next == FETCH && state != FETCH && state != RST_ST)
                ret_cnt <= ret_cnt + 32'd1;
        end
    end

    assign perf_cycles  = rst ? '0 : cyc_cnt;
    assign perf_retired = rst ? '0 : ret_cnt;
`else
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_mips_mc_controller_gen2.sv
// Directed bench for mips_mc_controller_gen2 (MEM_TIMEOUT=4): R/I/lw/sw/branch/jal/jr flows,
// watchdog, halt, illegal opcode, reset gating and the optional performance counters.
module tb_mips_mc_controller_gen2;
    logic        clk = 1'b0;
    logic        rst, mem_ready;
    logic [31:0] instr;
    logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite;
    logic        RegDst, RegWrite, JumpAndLink, ALUSrcA, halted, err;
    logic [1:0]  ALUSrcB, PCSource;
    logic [5:0]  ALUOp;
    logic [31:0] perf_cycles, perf_retired;
    logic [22:0] ctl;
    int          n_chk = 0, n_fail = 0, held;

    localparam logic [31:0] I_ADD   = 32'h0022_1820;
    localparam logic [31:0] I_LW    = 32'h8C22_0008;
    localparam logic [31:0] I_SW    = 32'hAC22_0008;
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_ADDIU = 32'h2422_0005;
    localparam logic [31:0] I_BEQ   = 32'h1022_0003;
    localparam logic [31:0] I_HALT  = 32'hFC00_0000;
    localparam logic [31:0] I_ILL   = 32'hEC00_0000;

    always #5 clk = ~clk;

    mips_mc_controller_gen2 #(.ALUOP_W(6), .MEM_TIMEOUT(4), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .RegDst(RegDst),
        .RegWrite(RegWrite), .JumpAndLink(JumpAndLink), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .halted(halted), .err(err),
        .perf_cycles(perf_cycles), .perf_retired(perf_retired)
    );

    assign ctl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst,
                  RegWrite, JumpAndLink, ALUSrcA, ALUSrcB, PCSource, ALUOp, halted, err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b1; instr = I_ADD;
        cyc(); cyc();
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_perf", perf_cycles | perf_retired, 32'h0);
        rst = 1'b0; #1;
        chk("rstst_ctl", 32'(ctl), 32'h0);

        // add: FETCH, DECODE, R_EXEC, R_WB, back to FETCH
        cyc();
        chk("add_f_memread", MemRead, 1); chk("add_f_irw_pcw", {IRWrite, PCWrite}, 2'b11);
        chk("add_f_srcb", ALUSrcB, 2'b01); chk("add_f_aluop", ALUOp, 6'b001001);
        cyc();
        chk("add_d_srcb", ALUSrcB, 2'b11); chk("add_d_memread", MemRead, 0);
        cyc();
        chk("add_x_src", {ALUSrcA, ALUSrcB}, 3'b100); chk("add_x_aluop", ALUOp, 6'b000000);
        chk("add_x_regwrite", RegWrite, 0);
        cyc();
        chk("add_wb_rw_rd", {RegWrite, RegDst}, 2'b11);
        cyc();
        chk("add_back_fetch", MemRead, 1);
        repeat (8) cyc();
`ifdef MC_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, 13);
        chk("perf_retired", perf_retired, 3);
`else
        chk("perf_cycles_off", perf_cycles, 0);
        chk("perf_retired_off", perf_retired, 0);
`endif

        // lw with three not-ready cycles; the fourth cycle is the last the watchdog allows
        instr = I_LW; #1;
        cyc();
        cyc();
        chk("lw_addr_src", {ALUSrcA, ALUSrcB}, 3'b110); chk("lw_addr_aluop", ALUOp, 6'b001001);
        mem_ready = 1'b0;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (MemRead && IorD) held++;
        end
        cyc();
        mem_ready = 1'b1; #1;
        if (MemRead && IorD) held++;
        chk("lw_held", held, 4);
        cyc();
        chk("lw_wb", {MemToReg, RegWrite, RegDst, MemRead, err}, 5'b11000);
        cyc();
        chk("lw_back_fetch", MemRead, 1);

        // jal then jr
        instr = I_JAL; #1;
        cyc(); cyc();
        chk("jal_ctl", {PCWrite, PCSource, JumpAndLink}, 4'b1101);
        cyc();
        chk("jal_link_1cyc", {JumpAndLink, PCSource}, 3'b000);
        instr = I_JR; #1;
        cyc(); cyc(); cyc();
        chk("jr_ctl", {PCWrite, PCSource, RegWrite}, 4'b1110);
        cyc();
        chk("jr_back_fetch", MemRead, 1);

        // addiu and beq
        instr = I_ADDIU; #1;
        cyc(); cyc();
        chk("addiu_x", {ALUSrcA, ALUSrcB, ALUOp}, {3'b110, 6'b001001});
        cyc();
        chk("addiu_wb", {RegWrite, RegDst}, 2'b10);
        cyc();
        instr = I_BEQ; #1;
        cyc(); cyc();
        chk("beq_ctl", {PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp}, {6'b101100, 6'b000100});
        cyc();
        chk("beq_back_fetch", MemRead, 1);

        // sw with memory never ready: four wait cycles, then ERROR
        instr = I_SW; #1;
        cyc(); cyc();
        mem_ready = 1'b0;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (MemWrite && IorD) held++;
        end
        chk("sw_wait_cycles", held, 4);
        cyc();
        chk("sw_tmo_err", {err, MemWrite}, 2'b10);
        mem_ready = 1'b1;
        cyc();
        chk("sw_err_sticky", 32'(ctl), 32'h1);
        rst = 1'b1; #1;
        chk("sw_err_rst_clear", err, 0);
        cyc();
        rst = 1'b0;

        // halt
        instr = I_HALT; #1;
        cyc(); cyc(); cyc();
        chk("halt_set", 32'(ctl), 32'h2);
        cyc(); cyc();
        chk("halt_held", halted, 1);
        rst = 1'b1; #1;
        chk("halt_rst", halted, 0);
        cyc();
        rst = 1'b0;

        // illegal opcode 0x3B
        instr = I_ILL; #1;
        cyc(); cyc(); cyc();
        chk("ill_err", 32'(ctl), 32'h1);
        rst = 1'b1;
        cyc();

        // reset while FETCH is waiting on memory
        rst = 1'b0; mem_ready = 1'b0;
        cyc(); cyc();
        chk("fetch_wait_memread", {MemRead, IRWrite}, 2'b10);
        rst = 1'b1; #1;
        chk("rst_mid_fetch", 32'(ctl), 32'h0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
